gpu_host_mem_bridge: RTL
========================

// Module: gpu_host_mem_bridge
// PURPOSE
//  Host-side request bridge feeding port B of the GPU dual-port RAM. Buffers host byte read/write
//  requests in a small FIFO and issues one per clock to RAM port B (addr_b/wr_en_b/data_in_b).
//  Returns read data from data_out_b with a response strobe aligned to the RAM's registered read latency.
// PARAMETERS
//  ADDR_SIZE   14   RAM address width; the RAM decodes only addr[ADDR_SIZE-1:0]
//  NUM_WORDS   2**ADDR_SIZE   RAM size in bytes; addresses >= NUM_WORDS are out of range
//  FIFO_DEPTH  4    request FIFO entries; power of two, >= 2
//  RD_LATENCY  2    clocks from addr_b presented to data_out_b valid (address reg + output reg)
// PORTS
//  clk         in   1   single clock; the same clock drives RAM port B (clk_b)
//  rst_n       in   1   asynchronous active-low reset
//  req_valid   in   1   host request present
//  req_ready   out  1   FIFO can accept; transfer occurs when req_valid & req_ready at posedge
//  req_wr      in   1   1 = write, 0 = read
//  req_addr    in   20  host byte address
//  req_wdata   in   8   write data
//  rsp_valid   out  1   one-cycle strobe: rsp_rdata holds read result
//  rsp_rdata   out  8   read data
//  range_err   out  1   sticky: an out-of-range request was seen (RANGE_CHECK_EN only, else 0)
//  addr_b      out  20  to RAM port B address (registered)
//  wr_en_b     out  1   to RAM port B write enable (registered)
//  data_in_b   out  8   to RAM port B write data (registered)
//  data_out_b  in   8   from RAM port B read data
// BEHAVIOUR
//  Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, range_err=0, addr_b=0, wr_en_b=0, data_in_b=0;
//   FIFO empty, read-tracking pipe cleared.
//  FIFO: req_ready = (count != FIFO_DEPTH). No bypass; an accepted entry is issuable the next cycle.
//   Push and pop in the same cycle: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Issue: every cycle FIFO non-empty -> pop head, register into addr_b/data_in_b, wr_en_b=head.wr.
//   Empty -> wr_en_b=0, addr_b/data_in_b hold their previous values. Throughput: 1 request/clk.
//  Reads: issued read pushes a 1 into a RD_LATENCY-deep valid pipe; on pipe exit rsp_valid=1 for
//   one cycle, rsp_rdata <= data_out_b (registered). Total read latency with empty FIFO: accept at
//   edge N -> rsp_valid high in the cycle after edge N+4. Responses are in order; no backpressure.
//  Writes produce no response. A read issued the cycle after a write to the same address returns
//   the new data (sequential port-B access).
//  Reset mid-operation: FIFO flushed, in-flight reads dropped (no rsp_valid), wr_en_b low.
// CONFIGURATION
//  `define GPU_HOST_BRIDGE_RANGE_CHECK_EN:
//   with it:  request with req_addr >= NUM_WORDS is accepted but issued with wr_en_b=0; a read
//            returns rsp_rdata=8'hFF at normal latency; range_err set, cleared only by reset.
//   without: no check; address truncated by RAM (aliasing); range_err tied 0.
// STRUCTURE
//  Package gpu_host_pkg: req_t struct {wr, addr[19:0], wdata[7:0]}, RD_LATENCY default,
//   RDATA_OOR = 8'hFF.
//  Sub-module gpu_host_req_fifo (synchronous FIFO of req_t, count-based full/empty).
// TESTING
//  Write 8'hA5 to 0x0010, then read 0x0010 -> wr_en_b pulse with addr_b=0x0010; rsp 8'hA5 at N+4.
//  Burst 6 reads with req_valid held, FIFO_DEPTH=4, empty start -> 6 in-order rsp_valid, consecutive.
//  Fill FIFO: stall RAM issue impossible, so push 4 same-cycle with pop -> req_ready stays 1; verify
//   count never exceeds 4 via FIFO assertion under random valid.
//  Assert rst_n low 1 cycle after a read issue -> no rsp_valid, wr_en_b=0, req_ready=1.
//  RANGE_CHECK_EN: write 0x4000 then read 0x4000 -> no wr_en_b pulse, rsp 8'hFF, range_err=1.
//  No RANGE_CHECK_EN: write 8'h3C to 0x4001 -> addr_b=0x4001, read 0x0001 returns 8'h3C.

Source files
------------

// File: rtl/gpu_host_pkg.sv
// Shared types and constants for the host-side port-B request bridge.
package gpu_host_pkg;

  localparam int unsigned HOST_ADDR_W    = 20;
  localparam int unsigned HOST_DATA_W    = 8;
  localparam int unsigned RD_LATENCY_DEF = 2;
  // Read data returned for an out-of-range request when range checking is built in
  localparam logic [HOST_DATA_W-1:0] RDATA_OOR = 8'hFF;

  typedef struct packed {
    logic                   wr;
    logic [HOST_ADDR_W-1:0] addr;
    logic [HOST_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/gpu_host_req_fifo.sv
// Synchronous request FIFO of req_t with count-based full/empty.
// No bypass: a pushed entry becomes visible at the head one cycle later.
module gpu_host_req_fifo
  import gpu_host_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t head,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  req_t            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gpu_host_mem_bridge.sv
// Host request bridge onto GPU RAM port B: buffers byte requests, issues one per clock,
// and returns read data with a strobe aligned to the RAM's registered read latency.
// Optional build macro: GPU_HOST_BRIDGE_RANGE_CHECK_EN (out-of-range requests are suppressed,
// reads of them return RDATA_OOR, and a sticky range_err flag is raised).
module gpu_host_mem_bridge
  import gpu_host_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 14,
  parameter int unsigned NUM_WORDS  = 2 ** ADDR_SIZE,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        range_err,
  output logic [19:0] addr_b,
  output logic        wr_en_b,
  output logic [7:0]  data_in_b,
  input  logic [7:0]  data_out_b
);

`ifdef GPU_HOST_BRIDGE_RANGE_CHECK_EN
  localparam bit RangeCheckEn = 1'b1;
`else
  localparam bit RangeCheckEn = 1'b0;
`endif

  req_t push_req, head;
  logic fifo_full, fifo_empty, push, pop;
  logic req_oor, head_oor;

  // Issue-stage flags travel alongside addr_b; the pipe covers the RAM's internal registers
  logic                  rd_iss_q, oor_iss_q;
  logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d, oor_pipe_q, oor_pipe_d;
  logic                  range_err_q;

  assign push_req  = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;
  assign pop       = ~fifo_empty;
  assign req_oor   = RangeCheckEn & (32'(req_addr) >= NUM_WORDS);
  assign head_oor  = RangeCheckEn & (32'(head.addr) >= NUM_WORDS);
  assign range_err = range_err_q;

  gpu_host_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Read-tracking shift: stage 0 is fed from the issue register
  always_comb begin
    rd_pipe_d     = '0;
    oor_pipe_d    = '0;
    rd_pipe_d[0]  = rd_iss_q;
    oor_pipe_d[0] = oor_iss_q;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      rd_pipe_d[i]  = rd_pipe_q[i-1];
      oor_pipe_d[i] = oor_pipe_q[i-1];
    end
  end

  // Issue register: pop the head every non-empty cycle; address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_b    <= '0;
      data_in_b <= '0;
      wr_en_b   <= 1'b0;
      rd_iss_q  <= 1'b0;
      oor_iss_q <= 1'b0;
    end else begin
      wr_en_b   <= pop & head.wr & ~head_oor;
      rd_iss_q  <= pop & ~head.wr;
      oor_iss_q <= pop & ~head.wr & head_oor;
      if (pop) begin
        addr_b    <= head.addr;
        data_in_b <= head.wdata;
      end
    end
  end

  // Response: strobe and capture RAM data as a tracked read leaves the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q  <= '0;
      oor_pipe_q <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      rd_pipe_q  <= rd_pipe_d;
      oor_pipe_q <= oor_pipe_d;
      rsp_valid  <= rd_pipe_q[RD_LATENCY-1];
      if (rd_pipe_q[RD_LATENCY-1]) begin
        rsp_rdata <= oor_pipe_q[RD_LATENCY-1] ? RDATA_OOR : data_out_b;
      end
    end
  end

  // Sticky out-of-range flag, flagged as soon as such a request is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      range_err_q <= 1'b0;
    end else if (push & req_oor) begin
      range_err_q <= 1'b1;
    end
  end

endmodule
